// File: rtl/fp_fma_issue_buffer_pkg.sv
// Shared request/response types for the FMA issue buffer and its result FIFO.
// This file holds type definitions only: no logic, no latency, no backpressure.
package fp_pkg;

    typedef logic [31:0] fp_32b_t;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    typedef struct packed {
        fp_32b_t    a;
        fp_32b_t    b;
        fp_32b_t    c;
        logic [2:0] rm;
    } fma_req_t;

    typedef struct packed {
        fp_32b_t   data;
        fp_flags_t flags;
    } fma_rsp_t;

    localparam int RSP_W = $bits(fma_rsp_t);

endpackage

// File: rtl/fp_sync_fifo.sv
// Generic synchronous FIFO with a registered head; push is visible on the head one cycle later.
// There is no internal flow control: the caller must never push when full or pop when empty.
module fp_sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH for free.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/fp_fma_issue_buffer.sv
// Credit-limited front end for a non-stallable FMA pipeline with an ordered result FIFO and sticky flags.
// Issue is registered one cycle; results pop no earlier than the cycle after capture; req_ready reserves a FIFO slot per op.
module fp_fma_issue_buffer
    import fp_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [31:0] req_c,
    input  logic [2:0]  req_rm,
    output logic        pipe_valid_in,
    output logic [31:0] pipe_in1,
    output logic [31:0] pipe_in2,
    output logic [31:0] pipe_in3,
    output logic [2:0]  pipe_rm,
    input  logic [31:0] pipe_out,
    input  logic        pipe_overflow,
    input  logic        pipe_underflow,
    input  logic        pipe_inexact,
    input  logic        pipe_invalid,
    input  logic        pipe_valid_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_flags,
    output logic [3:0]  sticky_flags,
    input  logic        clear_flags,
    output logic        protocol_err,
    output logic        busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_sum;
    logic          fifo_full, fifo_empty;
    logic          issue, capture, push, pop;
    logic          pipe_valid_in_q, pipe_valid_in_d;
    fma_req_t      pipe_req_q, pipe_req_d;
    fp_flags_t     sticky_q, sticky_d;
    logic          protocol_err_q, protocol_err_d;
    fma_rsp_t      push_rsp, head_rsp;

    // Every in-flight op already owns a FIFO slot, so frees this cycle are deliberately not counted.
    assign credit_sum = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign req_ready  = rst & (credit_sum < CREDITS);

    assign issue     = req_valid & req_ready;
    assign capture   = pipe_valid_out & (inflight_q != '0);
    assign push      = capture & ~fifo_full;
    assign rsp_valid = ~fifo_empty;
    assign pop       = rsp_valid & rsp_ready;

    assign push_rsp = '{data: pipe_out,
                        flags: '{invalid: pipe_invalid, overflow: pipe_overflow,
                                 underflow: pipe_underflow, inexact: pipe_inexact}};

    always_comb begin
        inflight_d      = inflight_q;
        pipe_valid_in_d = issue;
        pipe_req_d      = pipe_req_q;
        sticky_d        = sticky_q;
        protocol_err_d  = protocol_err_q | (pipe_valid_out & (inflight_q == '0));
        if (issue) begin
            pipe_req_d = '{a: req_a, b: req_b, c: req_c, rm: req_rm};
        end
        if (issue && !capture) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!issue && capture) begin
            inflight_d = inflight_q - CW'(1);
        end
        // Clear takes effect before the popped entry is folded in.
        if (clear_flags) begin
            sticky_d = '0;
        end
        if (pop) begin
            sticky_d = sticky_d | head_rsp.flags;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q      <= '0;
            pipe_valid_in_q <= 1'b0;
            pipe_req_q      <= '0;
            sticky_q        <= '0;
            protocol_err_q  <= 1'b0;
        end else begin
            inflight_q      <= inflight_d;
            pipe_valid_in_q <= pipe_valid_in_d;
            pipe_req_q      <= pipe_req_d;
            sticky_q        <= sticky_d;
            protocol_err_q  <= protocol_err_d;
        end
    end

    fp_sync_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .push     (push),
        .push_dat (push_rsp),
        .pop      (pop),
        .head_dat (head_rsp),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign pipe_valid_in = pipe_valid_in_q;
    assign pipe_in1      = pipe_req_q.a;
    assign pipe_in2      = pipe_req_q.b;
    assign pipe_in3      = pipe_req_q.c;
    assign pipe_rm       = pipe_req_q.rm;
    assign rsp_data      = head_rsp.data;
    assign rsp_flags     = head_rsp.flags;
    assign sticky_flags  = sticky_q;
    assign protocol_err  = protocol_err_q;
    assign busy          = (inflight_q != '0) | ~fifo_empty;

endmodule

// File: tb/tb_fp_fma_issue_buffer.sv
// Bench for fp_fma_issue_buffer: behavioural fixed-latency pipeline plus an ordered response scoreboard.
module tb_fp_fma_issue_buffer;

    localparam int DEPTH = 8;
    localparam int L     = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_a, req_b, req_c;
    logic [2:0]  req_rm;
    logic        pipe_valid_in;
    logic [31:0] pipe_in1, pipe_in2, pipe_in3;
    logic [2:0]  pipe_rm;
    logic [31:0] pipe_out;
    logic        pipe_overflow, pipe_underflow, pipe_inexact, pipe_invalid;
    logic        pipe_valid_out;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_flags, sticky_flags;
    logic        clear_flags, protocol_err, busy;

    always #5 clk = ~clk;

    fp_fma_issue_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_rm(req_rm),
        .pipe_valid_in(pipe_valid_in),
        .pipe_in1(pipe_in1), .pipe_in2(pipe_in2), .pipe_in3(pipe_in3), .pipe_rm(pipe_rm),
        .pipe_out(pipe_out), .pipe_overflow(pipe_overflow), .pipe_underflow(pipe_underflow),
        .pipe_inexact(pipe_inexact), .pipe_invalid(pipe_invalid), .pipe_valid_out(pipe_valid_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .sticky_flags(sticky_flags), .clear_flags(clear_flags),
        .protocol_err(protocol_err), .busy(busy)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [2:0]  rm;
        logic [31:0] res;
        logic [3:0]  flg;
    } op_t;

    op_t         ops_q[$];
    logic [35:0] exp_q[$];
    time         pop_times[$];
    op_t         cur_op;
    logic [35:0] exp_e;

    logic        st_v [L];
    logic [35:0] st_d [L];
    logic        model_vld, spur_vld;
    logic [31:0] model_out;
    logic [3:0]  model_flg;

    int n_chk = 0, n_pass = 0;
    int pop_cnt = 0, issue_cnt = 0, pvi_run = 0, pvi_max = 0;
    int p0, i0;

    assign pipe_valid_out = model_vld | spur_vld;
    assign pipe_out       = model_out;
    assign {pipe_invalid, pipe_overflow, pipe_underflow, pipe_inexact} = model_flg;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Fixed-latency pipeline model; it also checks the operands the DUT presents.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < L; i++) begin
                st_v[i] = 1'b0;
                st_d[i] = '0;
            end
            pvi_run = 0;
        end else begin
            for (int i = L - 1; i > 0; i--) begin
                st_v[i] = st_v[i-1];
                st_d[i] = st_d[i-1];
            end
            st_v[0] = 1'b0;
            if (pipe_valid_in) begin
                pvi_run++;
                if (ops_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL pipe_issue_unexpected: got pipe_valid_in=1, expected no issue");
                end else begin
                    cur_op = ops_q.pop_front();
                    chk("pipe_in1", pipe_in1, cur_op.a);
                    chk("pipe_in2", pipe_in2, cur_op.b);
                    chk("pipe_in3", pipe_in3, cur_op.c);
                    chk("pipe_rm",  pipe_rm,  cur_op.rm);
                    st_v[0] = 1'b1;
                    st_d[0] = {cur_op.res, cur_op.flg};
                end
            end else begin
                pvi_run = 0;
            end
            if (pvi_run > pvi_max) pvi_max = pvi_run;
            if (req_valid && req_ready) issue_cnt++;
        end
        model_vld = st_v[L-1];
        {model_out, model_flg} = st_d[L-1];
    end

    // Response monitor: every accepted response must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL rsp_unexpected: got data 0x%0h, expected no response", rsp_data);
            end else begin
                exp_e = exp_q.pop_front();
                chk("rsp_data",  rsp_data,  exp_e[35:4]);
                chk("rsp_flags", rsp_flags, exp_e[3:0]);
            end
            pop_times.push_back($time);
            pop_cnt++;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [2:0] rm, input logic [31:0] res, input logic [3:0] flg);
        int  t;
        op_t o;
        req_a = a; req_b = b; req_c = c; req_rm = rm;
        req_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", req_ready, 1);
        end else begin
            o = '{a: a, b: b, c: c, rm: rm, res: res, flg: flg};
            ops_q.push_back(o);
            exp_q.push_back({res, flg});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("idle_busy", busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; clear_flags = 1'b0; spur_vld = 1'b0;
        req_a = '0; req_b = '0; req_c = '0; req_rm = '0;
        #23;
        chk("rst_pipe_valid_in", pipe_valid_in, 0);
        chk("rst_req_ready_low", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sticky", sticky_flags, 0);
        chk("rst_protocol_err", protocol_err, 0);
        chk("rst_pipe_in1", pipe_in1, 0);
        chk("rst_rsp_data", rsp_data, 0);
        @(posedge clk); #1;

        // Single op: 2.0 * 3.0 + 1.0 = 7.0
        rsp_ready = 1'b1;
        p0 = pop_cnt;
        send(32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 3'd0, 32'h40E0_0000, 4'b0000);
        wait_idle();
        chk("single_pop_count", pop_cnt - p0, 1);
        chk("single_sticky", sticky_flags, 0);

        // Backpressure: eight credits then stall until a slot frees
        rsp_ready = 1'b0;
        i0 = issue_cnt;
        fork
            begin
                for (int k = 0; k < 9; k++)
                    send(32'h3F80_0000 + k, 32'h4000_0000, 32'h0000_0010 + k, 3'(k % 5),
                         32'hA000_0000 + k, 4'b0000);
            end
            begin
                repeat (40) @(negedge clk);
                chk("bp_issue_count", issue_cnt - i0, 8);
                chk("bp_req_ready", req_ready, 0);
                chk("bp_rsp_valid", rsp_valid, 1);
                chk("bp_head_stable", rsp_data, 32'hA000_0000);
                @(posedge clk); #1;
                rsp_ready = 1'b1;
            end
        join
        wait_idle();
        chk("bp_total_issue", issue_cnt - i0, 9);

        // Throughput: 20 back-to-back ops
        pvi_max = 0;
        pop_times.delete();
        for (int k = 0; k < 20; k++)
            send(32'h4100_0000 + k, 32'h4200_0000 - k, 32'h1234_0000 + k, 3'(k % 8),
                 32'hC000_0000 + k, 4'b0000);
        wait_idle();
        chk("tp_pvi_run", pvi_max, 20);
        chk("tp_pop_count", pop_times.size(), 20);
        if (pop_times.size() == 20)
            chk("tp_no_bubble", (pop_times[19] - pop_times[0]) / 10, 19);

        // Sticky accumulation, then clear coincident with a pop
        rsp_ready = 1'b0;
        send(32'h1, 32'h2, 32'h3, 3'd1, 32'h0000_1111, 4'b0001);
        send(32'h4, 32'h5, 32'h6, 3'd2, 32'h0000_2222, 4'b0100);
        send(32'h7, 32'h8, 32'h9, 3'd3, 32'h0000_3333, 4'b1000);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_idle();
        rsp_ready = 1'b0;
        chk("sticky_accum", sticky_flags, 4'b1101);
        send(32'hA, 32'hB, 32'hC, 3'd4, 32'h0000_4444, 4'b0010);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        rsp_ready = 1'b1; clear_flags = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0; clear_flags = 1'b0;
        @(negedge clk);
        chk("sticky_clear_pop", sticky_flags, 4'b0010);
        @(posedge clk); #1;

        // Reset mid-op: 3 in flight, 2 queued
        for (int k = 0; k < 5; k++)
            send(32'h5000_0000 + k, 32'h1, 32'h2, 3'd0, 32'hD000_0000 + k, 4'b0001);
        @(posedge clk); #1;
        chk("mid_rsp_valid_before", rsp_valid, 1);
        chk("mid_busy_before", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_sticky", sticky_flags, 0);
        chk("mid_pipe_valid_in", pipe_valid_in, 0);
        exp_q.delete();
        ops_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_req_ready_after", req_ready, 1);
        chk("mid_protocol_err", protocol_err, 0);
        @(posedge clk); #1;

        // Clear alone
        rsp_ready = 1'b1;
        send(32'h3F80_0000, 32'h3F80_0000, 32'h0, 3'd0, 32'h3F80_0000, 4'b0100);
        wait_idle();
        chk("sticky_single", sticky_flags, 4'b0100);
        clear_flags = 1'b1;
        @(posedge clk); #1;
        clear_flags = 1'b0;
        @(negedge clk);
        chk("sticky_clear_alone", sticky_flags, 0);
        @(posedge clk); #1;

        // Spurious pipeline output while idle
        p0 = pop_cnt;
        spur_vld = 1'b1;
        @(posedge clk); #1;
        spur_vld = 1'b0;
        @(negedge clk);
        chk("spur_protocol_err", protocol_err, 1);
        chk("spur_rsp_valid", rsp_valid, 0);
        chk("spur_busy", busy, 0);
        chk("spur_req_ready", req_ready, 1);
        repeat (5) @(negedge clk);
        chk("spur_err_sticky", protocol_err, 1);
        chk("spur_no_pop", pop_cnt - p0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        chk("spur_err_reset", protocol_err, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Normal operation after reset
        send(32'h4040_0000, 32'h4040_0000, 32'h0, 3'd0, 32'h4110_0000, 4'b0000);
        wait_idle();
        chk("final_drained", exp_q.size(), 0);
        chk("final_protocol_err", protocol_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fp_fma_issue_buffer.md
Name: fp_fma_issue_buffer

Overview:
- Host-side front end for fp_fused_mult_add_pipeline. It accepts (a*b)+c requests over valid/ready and drives the pipeline's in1/in2/in3/rounding_mode/valid_data_in.
- It captures out/flags on valid_data_out into a result FIFO and returns them over valid/ready.
- The pipeline cannot stall, so issue is credit-limited: an operation is issued only when its result is guaranteed a FIFO slot.
- It also keeps RISC-V-style sticky exception flags.

Parameters:
- DEPTH, 8, result FIFO entries and maximum outstanding credits; power of two, >=2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when high with req_valid
- req_a, req_b, req_c  in  32 each  operands, computing (a*b)+c
- req_rm  in  3  rounding mode
- pipe_valid_in  out  1  to pipeline valid_data_in
- pipe_in1, pipe_in2, pipe_in3  out  32 each  to pipeline operands
- pipe_rm  out  3  to pipeline rounding_mode
- pipe_out  in  32  pipeline result
- pipe_overflow, pipe_underflow, pipe_inexact, pipe_invalid  in  1 each  pipeline flags
- pipe_valid_out  in  1  pipeline valid_data_out
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_data  out  32  result
- rsp_flags  out  4  {invalid, overflow, underflow, inexact}
- sticky_flags  out  4  accumulated flags, same bit order
- clear_flags  in  1  clear sticky_flags
- protocol_err  out  1  sticky; set on pipe_valid_out while nothing is in flight
- busy  out  1  in-flight != 0 or FIFO non-empty

Behaviour:
- Reset (rst low, async): all outputs and state are 0, including counters, FIFO pointers, pipe_* outputs, sticky_flags and protocol_err. In the first cycle after release, req_ready=1.
- Counters: inflight and fifo_count are each $clog2(DEPTH+1) bits.
  - Credit: req_ready = (inflight + fifo_count) < DEPTH, combinational from registered state only. It does not depend on req_valid and does not see same-cycle frees.
- Issue: when req_valid & req_ready at edge T:
  - pipe_in1/2/3 and pipe_rm register req_a/b/c and req_rm.
  - pipe_valid_in=1 during cycle T+1, then 0 unless another issue occurs. Back-to-back issue every cycle is allowed.
  - Operand registers hold their last value when not issuing.
- inflight: +1 on issue, -1 on accepted pipe_valid_out. Both in the same cycle leaves it unchanged.
- Capture: on pipe_valid_out with inflight != 0, push {pipe_out, flags} into the FIFO. The credit invariant guarantees the FIFO is never full on push.
  - pipe_valid_out with inflight == 0: drop the data, set protocol_err (cleared only by reset), no counter change.
- Response:
  - rsp_valid = FIFO non-empty.
  - rsp_data and rsp_flags show the head entry and are stable while rsp_valid & ~rsp_ready.
  - Pop on rsp_valid & rsp_ready.
  - No bypass: minimum latency is req handshake at T, rsp_valid at T+2+L, where L is pipeline latency.
  - Simultaneous push and pop: count unchanged, ordering preserved.
- Pointers wrap modulo DEPTH.
- Sticky flags:
  - On pop: sticky_flags |= head rsp_flags.
  - clear_flags with pop in the same cycle: sticky_flags = popped entry flags (clear first, then OR).
  - clear_flags alone: sticky_flags = 0.
- Results return in issue order; the pipeline is in-order.
- Reset mid-operation discards in-flight and queued results. Any pipe_valid_out arriving after reset from a pre-reset issue is treated as spurious and sets protocol_err. Integration must reset both blocks together.

Decomposition:
- In fp_pkg:
  - typedef fp_flags_t: packed struct {invalid, overflow, underflow, inexact}.
  - typedef fma_req_t: {a, b, c, rm}.
  - typedef fma_rsp_t: {fp_32b_t data, fp_flags_t flags}.
- One sub-module: fp_sync_fifo (params WIDTH, DEPTH; push, pop, full, empty, count, head data; async active-low reset). It stores fma_rsp_t, so WIDTH=36.

Test Plan:
- Single op: a=0x40000000, b=0x40400000, c=0x3F800000, rm=0, pipeline returns 0x40E00000 with flags 0. Expect exactly one rsp_valid, rsp_data=0x40E00000, rsp_flags=0, sticky_flags=0; busy falls after the pop.
- Backpressure: rsp_ready=0, req_valid held 1, DEPTH=8. Expect exactly 8 issues, then req_ready=0 until the first pop. After rsp_ready=1, all 8 results return in order; FIFO never overflows.
- Throughput: rsp_ready=1, 20 back-to-back requests. Expect pipe_valid_in high 20 consecutive cycles and responses in order with no bubble once steady.
- Sticky flags: results with flags 0b0001, 0b0100, 0b1000 popped, giving sticky_flags=0b1101. Then clear_flags asserted in the same cycle as a pop with flags 0b0010 gives sticky_flags=0b0010.
- Spurious: pipe_valid_out=1 with inflight=0. Expect protocol_err=1, no rsp_valid, counts unchanged; protocol_err cleared only by rst low.
- Reset mid-op: 3 in flight and 2 queued, assert rst asynchronously mid-cycle. Expect rsp_valid=0, busy=0, sticky_flags=0 and pipe_valid_in=0 immediately, and req_ready=1 after release.
